digit_entry_ctrl: RTL and testbench
===================================

// Module: digit_entry_ctrl
// PURPOSE
//  Sequences hex keypad entry into the 8-digit seven-segment display bank.
//  Turns raw pushbutton levels into single debounced key events and owns the cursor.
//  Runs an IDLE/EDIT/COMMIT state machine and hands the finished value to the
//  consumer over a valid/ready handshake.
//  Sits between the pushbutton inputs of top and the seven_seg decoder
//  (digits/flt_pt feed the decoder directly).
// PARAMETERS
//  NDIGITS       8  number of 4-bit display digits; cursor width = $clog2(NDIGITS)
//  DEBOUNCE_CYC  2  consecutive all-keys-released cycles required before the next event
// PORTS
//  CLK           in   1          system clock (hz100 at top)
//  RST           in   1          synchronous, active-high reset
//  hex_keys      in   16         one bit per hex key 0..F (pb[15:0])
//  shift_key     in   1          move cursor left (+1)
//  back_key      in   1          clear digit at cursor, move cursor -1
//  enter_key     in   1          commit current digits
//  clear_key     in   1          zero all digits, cursor to 0
//  commit_ready  in   1          consumer accepts commit_value
//  digits        out  NDIGITSx4  display digits, digits[0] rightmost
//  flt_pt        out  NDIGITS    one-hot cursor marker
//  commit_valid  out  1          commit_value valid; held until commit_ready
//  commit_value  out  4*NDIGITS  snapshot of digits at enter
// BEHAVIOUR
//  - One clock (CLK); reset is synchronous and active-high (RST).
//  - Reset values: digits=0, cursor=0, state=IDLE, flt_pt=0, commit_valid=0,
//    commit_value=0, lockout clear.
//  - Key sampling: all 20 key inputs are registered once (key_q).
//  - Event condition: key_q has exactly one bit set and lockout is clear.
//    The event fires for one cycle and sets lockout.
//  - Multi-key: two or more bits set in key_q produce no event but still set lockout.
//  - Lockout release: lockout clears only after key_q==0 for DEBOUNCE_CYC consecutive
//    cycles. Any nonzero key_q during the count restarts it.
//  - Latency: a key high before edge k is in key_q after k, the event is evaluated on
//    edge k+1, and digits/cursor are updated after edge k+1.
//  - IDLE
//      hex key -> digits[cursor] = key value, go EDIT
//      shift   -> cursor+1, go EDIT
//      clear   -> zero digits, cursor=0
//      back, enter -> ignored
//  - EDIT
//      hex key -> write digits[cursor]
//      shift   -> cursor = cursor+1, wraps NDIGITS-1 -> 0
//      back    -> digits[cursor]=0, cursor saturates at 0 (no wrap)
//      enter   -> commit_value=digits, commit_valid=1, go COMMIT
//      clear   -> digits=0, cursor=0, go IDLE
//  - COMMIT: all key events are dropped (lockout tracking continues).
//    On commit_valid && commit_ready: commit_valid=0, cursor=0, go IDLE.
//    digits are retained.
//  - Stability: commit_value is stable while commit_valid=1.
//  - flt_pt: 1<<cursor in EDIT; all-zero in IDLE and COMMIT.
//  - Reset mid-COMMIT: commit_valid drops on the reset edge with no handshake, and all
//    state returns to reset values.
// CONFIGURATION
//  - AUTO_ADVANCE_EN defined: every accepted hex write also advances the cursor by +1,
//    with the same NDIGITS-1 -> 0 wrap.
//  - Not defined: a hex write leaves the cursor unchanged; only shift/back move it.
// STRUCTURE
//  - digit_entry_pkg holds:
//      typedef enum logic [1:0] {IDLE, EDIT, COMMIT} entry_state_t;
//      key index localparams (KEY_SHIFT=16, KEY_BACK=17, KEY_ENTER=18, KEY_CLEAR=19);
//      NKEYS=20.
//  - Sub-module key_event: input register, one-hot check, lockout/debounce counter.
//    Outputs a one-cycle event_valid plus a 5-bit event_code.
//  - Top level holds the FSM, cursor, digit register bank and commit register.
// TESTING
//  1. Reset, press hex_keys[5], release
//     -> digits[0]=5, state EDIT, flt_pt=8'b0000_0001, exactly one write.
//  2. Hold hex_keys[3] for 10 cycles -> only one write. Release for 1 cycle, press
//     again (DEBOUNCE_CYC=2) -> ignored. Release for 2 cycles, press -> accepted.
//  3. Press hex_keys[1]|hex_keys[2] together -> no digit change.
//     A single key pressed after release -> accepted.
//  4. Shift 8 times from cursor 0 -> cursor back to 0 (wrap).
//     Back at cursor 0 -> digits[0]=0, cursor stays 0.
//  5. Type 0x1234ABCD, enter with commit_ready=0 for 5 cycles
//     -> commit_valid held, commit_value=32'h1234ABCD, keys ignored.
//     ready=1 -> valid drops the next cycle, state IDLE.
//  6. Assert RST during COMMIT -> commit_valid=0, digits=0 after the edge.
//     With AUTO_ADVANCE_EN: typing 3 digits -> cursor=3.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg: shared state encoding and key indices for the digit entry block.
package digit_entry_pkg;

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} entry_state_t;

    localparam int NKEYS = 20;
    localparam logic [4:0] KEY_SHIFT = 5'd16;
    localparam logic [4:0] KEY_BACK  = 5'd17;
    localparam logic [4:0] KEY_ENTER = 5'd18;
    localparam logic [4:0] KEY_CLEAR = 5'd19;

endpackage

// File: rtl/digit_entry_ctrl_key_event.sv
// key_event: registers the raw keys and emits one event per debounced single-key press.
module key_event #(
    parameter int NKEYS        = 20,
    parameter int DEBOUNCE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NKEYS-1:0] i_keys,
    output logic             o_event_valid,
    output logic [4:0]       o_event_code
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [NKEYS-1:0] r_key_q;
    logic             r_lock;
    logic [CW-1:0]    r_cnt;
    logic             w_onehot;
    logic [4:0]       w_code;

    assign w_onehot      = (r_key_q != '0) && ((r_key_q & (r_key_q - NKEYS'(1))) == '0);
    assign o_event_valid = w_onehot && !r_lock;
    assign o_event_code  = w_code;

    always_comb begin
        w_code = '0;
        for (int i = 0; i < NKEYS; i++)
            if (r_key_q[i]) w_code = 5'(i);
    end

    // Any key activity (single or multi) arms the lockout; only a clean run of idle cycles clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_key_q <= '0;
            r_lock  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_key_q <= i_keys;
            if (r_key_q != '0) begin
                r_lock <= 1'b1;
                r_cnt  <= '0;
            end else if (r_lock) begin
                r_lock <= (r_cnt != CW'(DEBOUNCE_CYC - 1));
                r_cnt  <= (r_cnt == CW'(DEBOUNCE_CYC - 1)) ? '0 : r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: hex keypad entry FSM, cursor, digit bank and commit handshake.
// Define AUTO_ADVANCE_EN to make every hex write advance the cursor.
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int NDIGITS      = 8,
    parameter int DEBOUNCE_CYC = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [15:0]            hex_keys,
    input  logic                   shift_key,
    input  logic                   back_key,
    input  logic                   enter_key,
    input  logic                   clear_key,
    input  logic                   commit_ready,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [NDIGITS-1:0]     flt_pt,
    output logic                   commit_valid,
    output logic [4*NDIGITS-1:0]   commit_value
);
    localparam int CW = $clog2(NDIGITS);
`ifdef AUTO_ADVANCE_EN
    localparam bit AUTO_ADV = 1'b1;
`else
    localparam bit AUTO_ADV = 1'b0;
`endif

    entry_state_t         r_state, w_state_n;
    logic [CW-1:0]        r_cursor, w_cur_n, w_cur_inc, w_cur_dec, w_cur_hex;
    logic [4*NDIGITS-1:0] r_digits, w_dig_n, r_commit_value, w_cval_n;
    logic [NDIGITS-1:0]   r_flt_pt;
    logic                 r_commit_valid, w_cv_n;
    logic [NKEYS-1:0]     w_keys;
    logic                 w_ev, w_is_hex;
    logic [4:0]           w_code;

    assign w_keys = {clear_key, enter_key, back_key, shift_key, hex_keys};

    key_event #(.NKEYS(NKEYS), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_event (
        .CLK           (CLK),
        .RST           (RST),
        .i_keys        (w_keys),
        .o_event_valid (w_ev),
        .o_event_code  (w_code)
    );

    assign w_is_hex  = ~w_code[4];
    assign w_cur_inc = (r_cursor == CW'(NDIGITS - 1)) ? '0 : r_cursor + CW'(1);
    assign w_cur_dec = (r_cursor == '0) ? '0 : r_cursor - CW'(1);
    assign w_cur_hex = AUTO_ADV ? w_cur_inc : r_cursor;

    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cursor;
        w_dig_n   = r_digits;
        w_cv_n    = r_commit_valid;
        w_cval_n  = r_commit_value;
        case (r_state)
            IDLE: if (w_ev) begin
                if (w_is_hex) begin
                    w_dig_n[{r_cursor, 2'b00} +: 4] = w_code[3:0];
                    w_cur_n   = w_cur_hex;
                    w_state_n = EDIT;
                end else if (w_code == KEY_SHIFT) begin
                    w_cur_n   = w_cur_inc;
                    w_state_n = EDIT;
                end else if (w_code == KEY_CLEAR) begin
                    w_dig_n = '0;
                    w_cur_n = '0;
                end
            end
            EDIT: if (w_ev) begin
                if (w_is_hex) begin
                    w_dig_n[{r_cursor, 2'b00} +: 4] = w_code[3:0];
                    w_cur_n = w_cur_hex;
                end else if (w_code == KEY_SHIFT) begin
                    w_cur_n = w_cur_inc;
                end else if (w_code == KEY_BACK) begin
                    w_dig_n[{r_cursor, 2'b00} +: 4] = 4'h0;
                    w_cur_n = w_cur_dec;
                end else if (w_code == KEY_ENTER) begin
                    w_cval_n  = r_digits;
                    w_cv_n    = 1'b1;
                    w_state_n = COMMIT;
                end else begin
                    w_dig_n   = '0;
                    w_cur_n   = '0;
                    w_state_n = IDLE;
                end
            end
            COMMIT: if (r_commit_valid && commit_ready) begin
                w_cv_n    = 1'b0;
                w_cur_n   = '0;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= IDLE;
            r_cursor       <= '0;
            r_digits       <= '0;
            r_flt_pt       <= '0;
            r_commit_valid <= 1'b0;
            r_commit_value <= '0;
        end else begin
            r_state        <= w_state_n;
            r_cursor       <= w_cur_n;
            r_digits       <= w_dig_n;
            r_flt_pt       <= (w_state_n == EDIT) ? NDIGITS'(1) << w_cur_n : '0;
            r_commit_valid <= w_cv_n;
            r_commit_value <= w_cval_n;
        end
    end

    assign digits       = r_digits;
    assign flt_pt       = r_flt_pt;
    assign commit_valid = r_commit_valid;
    assign commit_value = r_commit_value;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl: directed + random keypad stimulus against a behavioural entry model,
// with a commit scoreboard drained by an independent handshake monitor.
module tb_digit_entry_ctrl;
    localparam int ND = 8;
`ifdef AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        CLK = 1'b0, RST = 1'b1;
    logic [15:0] hex_keys = '0;
    logic        shift_key = 1'b0, back_key = 1'b0, enter_key = 1'b0, clear_key = 1'b0;
    logic        commit_ready = 1'b0;
    logic [31:0] digits, commit_value;
    logic [7:0]  flt_pt;
    logic        commit_valid;

    int          n_chk = 0, n_err = 0, zrun = 100;
    logic [31:0] sb[$];
    int          m_dig[ND];
    int          m_cur = 0, m_st = 0;   // m_st: 0 idle, 1 editing, 2 waiting for consumer
    logic        pv_v = 1'b0;
    logic [31:0] pv_val = '0;
    wire  [19:0] all_keys = {clear_key, enter_key, back_key, shift_key, hex_keys};

    always #5 CLK = ~CLK;

    digit_entry_ctrl dut (
        .CLK(CLK), .RST(RST), .hex_keys(hex_keys), .shift_key(shift_key),
        .back_key(back_key), .enter_key(enter_key), .clear_key(clear_key),
        .commit_ready(commit_ready), .digits(digits), .flt_pt(flt_pt),
        .commit_valid(commit_valid), .commit_value(commit_value)
    );

    // Length of the current run of all-released input cycles, as seen by the key register.
    always @(posedge CLK)
        zrun <= RST ? 100 : (all_keys != '0) ? 0 : (zrun < 100) ? zrun + 1 : 100;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] hk(int v);
        logic [19:0] one = 20'd1;
        return one << v;
    endfunction

    function automatic logic [31:0] m_pack();
        logic [31:0] r = '0;
        for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'(m_dig[i]);
        return r;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_cur = 0;
    endtask

    task automatic model_key(int k);
        if (m_st == 0) begin
            if (k < 16) begin
                m_dig[m_cur] = k;
                if (AUTO) m_cur = (m_cur + 1) % ND;
                m_st = 1;
            end else if (k == 16) begin
                m_cur = (m_cur + 1) % ND;
                m_st = 1;
            end else if (k == 19) m_clear();
        end else if (m_st == 1) begin
            if (k < 16) begin
                m_dig[m_cur] = k;
                if (AUTO) m_cur = (m_cur + 1) % ND;
            end else if (k == 16) m_cur = (m_cur + 1) % ND;
            else if (k == 17) begin
                m_dig[m_cur] = 0;
                if (m_cur > 0) m_cur--;
            end else if (k == 18) begin
                sb.push_back(m_pack());
                m_st = 2;
            end else begin
                m_clear();
                m_st = 0;
            end
        end
    endtask

    task automatic check_state(string nm);
        logic [7:0] ef;
        ef = (m_st == 1) ? 8'(1 << m_cur) : 8'h00;
        chk({nm, " digits"}, digits, m_pack());
        chk({nm, " flt_pt"}, {24'h0, flt_pt}, {24'h0, ef});
        chk({nm, " valid"}, {31'h0, commit_valid}, {31'h0, m_st == 2});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called at a falling edge; drives a key pattern, releases, then checks the model.
    task automatic press(logic [19:0] pat, int hold, int rel, string nm);
        bit acc;
        acc = ($countones(pat) == 1) && (zrun >= 2);
        {clear_key, enter_key, back_key, shift_key, hex_keys} = pat;
        repeat (hold) tick();
        {clear_key, enter_key, back_key, shift_key, hex_keys} = '0;
        repeat (rel) tick();
        @(negedge CLK);
        if (acc)
            for (int i = 0; i < 20; i++)
                if (pat[i]) model_key(i);
        check_state(nm);
    endtask

    task automatic ack();
        int n = 0;
        commit_ready = 1'b1;
        do begin
            tick();
            n++;
        end while (commit_valid && n < 10);
        commit_ready = 1'b0;
        chk("ack latency", n, 1);
        m_st  = 0;
        m_cur = 0;
        @(negedge CLK);
        check_state("after ack");
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        chk("reset valid", {31'h0, commit_valid}, 32'h0);
        chk("reset digits", digits, 32'h0);
        RST = 1'b0;
        sb.delete();
        m_clear();
        m_st = 0;
        @(negedge CLK);
        check_state("post reset");
    endtask

    // Scoreboard monitor: pops an expected commit at every accepted handshake.
    always @(negedge CLK) begin
        #1;
        if (commit_valid && pv_v) chk("value stable", commit_value, pv_val);
        if (commit_valid && commit_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_empty: handshake with value %h, none expected", commit_value);
            end else chk("commit value", commit_value, sb.pop_front());
        end
        pv_v   = commit_valid;
        pv_val = commit_value;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t5[8] = '{13, 12, 11, 10, 4, 3, 2, 1};
        m_clear();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst digits", digits, 32'h0);
        chk("rst flt_pt", {24'h0, flt_pt}, 32'h0);
        chk("rst valid", {31'h0, commit_valid}, 32'h0);
        chk("rst value", commit_value, 32'h0);

        press(hk(5), 1, 3, "t1 key5");
        chk("t1 flt_pt", {24'h0, flt_pt}, AUTO ? 32'h2 : 32'h1);

        press(hk(3), 10, 1, "t2 hold3");
        press(hk(7), 1, 2, "t2 early");
        press(hk(9), 1, 2, "t2 after gap");

        press(hk(1) | hk(2), 1, 2, "t3 multi");
        press(hk(4), 1, 2, "t3 single");

        m_cur = m_cur;
        while (m_cur != 0) press(hk(16), 1, 2, "t4 align");
        for (int i = 0; i < ND; i++) press(hk(16), 1, 2, "t4 shift");
        press(hk(17), 1, 2, "t4 back at 0");

        for (int i = 0; i < ND; i++) begin
            press(hk(t5[i]), 1, 2, "t5 type");
            if (!AUTO && i < ND - 1) press(hk(16), 1, 2, "t5 shift");
        end
        press(hk(18), 1, 2, "t5 enter");
        press(hk(6), 1, 3, "t5 key in commit");
        chk("t5 held valid", {31'h0, commit_valid}, 32'h1);
        chk("t5 value", commit_value, 32'h1234ABCD);
        ack();
        press(hk(16), 1, 2, "t5 idle shift");

        press(hk(7), 1, 2, "t6 type");
        press(hk(18), 1, 2, "t6 enter");
        do_reset();
        for (int i = 0; i < 3; i++) press(hk(i + 10), 1, 2, "t6 three");
`ifdef AUTO_ADVANCE_EN
        chk("t6 auto cursor", {24'h0, flt_pt}, 32'h8);
`endif

        for (int it = 0; it < 300; it++) begin
            int r, a, b;
            logic [19:0] pat;
            if (m_st == 2 && $urandom_range(0, 2) == 0) ack();
            r = $urandom_range(0, 11);
            a = $urandom_range(0, 19);
            b = (a + 1 + $urandom_range(0, 18)) % 20;
            pat = (r <= 4) ? hk($urandom_range(0, 15)) :
                  (r == 5) ? hk(16) : (r == 6) ? hk(17) : (r == 7) ? hk(18) :
                  (r == 8) ? hk(19) : (r == 9) ? (hk(a) | hk(b)) : hk($urandom_range(0, 15));
            if (r == 11 && $urandom_range(0, 7) == 0) do_reset();
            else press(pat, $urandom_range(1, 4), $urandom_range(1, 3), "rand");
        end
        if (m_st == 2) ack();
        chk("sb drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
